// File: rtl/shift_sequencer.sv
// Shares one 4-bit, 1-cycle-latency barrel shifter between two requesters and extends its reach
// by splitting each logical shift into passes of at most 3 positions.
module shift_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clock,
  input  logic             reset,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_left,
  input  logic [AMT_W-1:0] req0_amt,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_left,
  input  logic [AMT_W-1:0] req1_amt,

  output logic [WIDTH-1:0] sh_in,
  output logic [1:0]       sh_sa,
  output logic             sh_left,
  input  logic [WIDTH-1:0] sh_out,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] work_q;
  logic [AMT_W-1:0] rem_q;
  logic             dir_q;
  logic             id_q;
  logic             rr_last_q;

  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] sel_data;
  logic             sel_left;
  logic [AMT_W-1:0] sel_amt;

  // Largest step the shifter can take in one pass.
  function automatic logic [1:0] pass_amt(input logic [AMT_W-1:0] amt);
    if (amt > AMT_W'(3)) begin
      return 2'd3;
    end
    return amt[1:0];
  endfunction

  // Round-robin: on contention the requester that was not served last wins.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | rr_last_q);
    grant1 = req1_valid & (~req0_valid | ~rr_last_q);
  end

  always_comb begin
    sel_data = grant1 ? req1_data : req0_data;
    sel_left = grant1 ? req1_left : req0_left;
    sel_amt  = grant1 ? req1_amt  : req0_amt;
  end

  always_comb begin
    req0_ready = (state_q == StIdle) & grant0;
    req1_ready = (state_q == StIdle) & grant1;
  end

  always_comb begin
    rsp_valid = (state_q == StDone);
    rsp_id    = id_q;
    rsp_data  = work_q;
  end

  // sh_* are loaded on entry to StIssue so the shifter sees them during the issue cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      work_q    <= '0;
      rem_q     <= '0;
      dir_q     <= 1'b0;
      id_q      <= 1'b0;
      rr_last_q <= 1'b1;
      sh_in     <= '0;
      sh_sa     <= 2'd0;
      sh_left   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant0 | grant1) begin
            work_q    <= sel_data;
            rem_q     <= sel_amt;
            dir_q     <= sel_left;
            id_q      <= grant1;
            rr_last_q <= grant1;
            sh_in     <= sel_data;
            sh_sa     <= pass_amt(sel_amt);
            sh_left   <= sel_left;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          rem_q   <= rem_q - AMT_W'(pass_amt(rem_q));
          state_q <= StWait;
        end
        StWait: begin
          work_q <= sh_out;
          if (rem_q == '0) begin
            sh_sa   <= 2'd0;
            state_q <= StDone;
          end else begin
            sh_in   <= sh_out;
            sh_sa   <= pass_amt(rem_q);
            sh_left <= dir_q;
            state_q <= StIssue;
          end
        end
        StDone: begin
          if (rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: models the external shifter and compares the DUT against a
// plain-arithmetic reference of multi-pass logical shifts and round-robin ordering.
module tb_shift_sequencer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned AMT_W = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready, req0_left;
  logic [WIDTH-1:0] req0_data;
  logic [AMT_W-1:0] req0_amt;
  logic             req1_valid, req1_ready, req1_left;
  logic [WIDTH-1:0] req1_data;
  logic [AMT_W-1:0] req1_amt;
  logic [WIDTH-1:0] sh_in, sh_out;
  logic [1:0]       sh_sa;
  logic             sh_left;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0] rsp_data;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_left  (req0_left),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_left  (req1_left),
    .req1_amt   (req1_amt),
    .sh_in      (sh_in),
    .sh_sa      (sh_sa),
    .sh_left    (sh_left),
    .sh_out     (sh_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
  );

  always #5 clock = ~clock;

  // External registered barrel shifter.
  always @(posedge clock) begin
    sh_out <= sh_left ? (sh_in << sh_sa) : (sh_in >> sh_sa);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d, input logic left,
                                                 input int amt);
    if (amt >= int'(WIDTH)) return '0;
    return left ? WIDTH'(d << amt) : WIDTH'(d >> amt);
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic scramble();
    req0_data = WIDTH'($urandom);
    req0_left = 1'($urandom);
    req0_amt  = AMT_W'($urandom);
    req1_data = WIDTH'($urandom);
    req1_left = 1'($urandom);
    req1_amt  = AMT_W'($urandom);
  endtask

  // One request from an idle block, with an optional response stall.
  task automatic serve(input int id, input logic [WIDTH-1:0] d, input logic left, input int amt,
                       input int stall);
    int chunks[$];
    int rem;
    int done_amt;
    int p;
    logic [WIDTH-1:0] expv;
    rem = amt;
    do begin
      chunks.push_back(rem > 3 ? 3 : rem);
      rem -= chunks[$];
    end while (rem > 0);
    p = chunks.size();
    expv = ref_shift(d, left, amt);
    if (id == 0) begin
      req0_valid = 1'b1; req0_data = d; req0_left = left; req0_amt = AMT_W'(amt);
    end else begin
      req1_valid = 1'b1; req1_data = d; req1_left = left; req1_amt = AMT_W'(amt);
    end
    sample();
    check("ready_granted", 32'(id == 0 ? req0_ready : req1_ready), 1);
    check("ready_other", 32'(id == 0 ? req1_ready : req0_ready), 0);
    next_cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    scramble();
    done_amt = 0;
    for (int c = 0; c < 2 * p; c++) begin
      sample();
      check("rsp_valid_busy", 32'(rsp_valid), 0);
      if (c % 2 == 0) begin
        check("sh_sa", 32'(sh_sa), 32'(chunks[c / 2]));
        check("sh_in", 32'(sh_in), 32'(ref_shift(d, left, done_amt)));
        check("sh_left", 32'(sh_left), 32'(left));
        done_amt += chunks[c / 2];
      end
      next_cycle();
    end
    if (stall > 0) begin
      rsp_ready  = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
    end
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) rsp_ready = 1'b1;
      sample();
      check("rsp_valid", 32'(rsp_valid), 1);
      check("rsp_data", 32'(rsp_data), 32'(expv));
      check("rsp_id", 32'(rsp_id), 32'(id));
      check("sh_sa_done", 32'(sh_sa), 0);
      check("ready0_done", 32'(req0_ready), 0);
      check("ready1_done", 32'(req1_ready), 0);
      next_cycle();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  logic             g0, g1;
  int               exp_grant;
  int               rsps;
  int               q_id[$];
  logic [WIDTH-1:0] q_data[$];

  initial begin
    reset      = 1'b1;
    rsp_ready  = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    scramble();
    next_cycle();
    next_cycle();
    reset = 1'b0;
    sample();
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_sh_in", 32'(sh_in), 0);
    check("rst_sh_sa", 32'(sh_sa), 0);
    check("rst_sh_left", 32'(sh_left), 0);
    next_cycle();

    serve(0, 4'b1011, 1'b0, 2, 0);
    serve(1, 4'b1011, 1'b1, 1, 0);
    serve(1, 4'b0001, 1'b1, 5, 0);
    serve(0, 4'b1011, 1'b0, 7, 0);
    serve(0, 4'b1011, 1'b0, 0, 0);
    serve(1, 4'b0110, 1'b0, 1, 4);

    // Both requesters valid continuously from reset.
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    scramble();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    exp_grant  = 0;
    rsps       = 0;
    for (int cyc = 0; cyc < 300 && rsps < 8; cyc++) begin
      sample();
      g0 = req0_valid & req0_ready;
      g1 = req1_valid & req1_ready;
      if (g0 | g1) begin
        check("arb_single", 32'(g0 & g1), 0);
        check("arb_grant", 32'(g1), 32'(exp_grant));
        q_id.push_back(g1 ? 1 : 0);
        q_data.push_back(g1 ? ref_shift(req1_data, req1_left, int'(req1_amt))
                            : ref_shift(req0_data, req0_left, int'(req0_amt)));
        exp_grant ^= 1;
      end
      if (rsp_valid & rsp_ready) begin
        if (q_id.size() == 0) begin
          check("arb_unexpected_rsp", 32'(rsp_valid), 0);
        end else begin
          check("arb_rsp_id", 32'(rsp_id), 32'(q_id.pop_front()));
          check("arb_rsp_data", 32'(rsp_data), 32'(q_data.pop_front()));
        end
        rsps++;
      end
      next_cycle();
      if (g0) begin
        req0_data = WIDTH'($urandom); req0_left = 1'($urandom); req0_amt = AMT_W'($urandom);
      end
      if (g1) begin
        req1_data = WIDTH'($urandom); req1_left = 1'($urandom); req1_amt = AMT_W'($urandom);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("arb_rsp_count", 32'(rsps), 8);
    check("arb_outstanding", 32'(q_id.size()), 0);

    // Reset during the first wait of a 3-pass request.
    req0_valid = 1'b1; req0_data = 4'b1011; req0_left = 1'b0; req0_amt = 3'd7;
    sample();
    check("mid_ready0", 32'(req0_ready), 1);
    next_cycle();
    req0_valid = 1'b0;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    sample();
    check("mid_rsp_valid", 32'(rsp_valid), 0);
    check("mid_rsp_id", 32'(rsp_id), 0);
    check("mid_rsp_data", 32'(rsp_data), 0);
    check("mid_ready0_0", 32'(req0_ready), 0);
    check("mid_ready1_0", 32'(req1_ready), 0);
    check("mid_sh_in", 32'(sh_in), 0);
    check("mid_sh_sa", 32'(sh_sa), 0);
    check("mid_sh_left", 32'(sh_left), 0);
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      sample();
      check("mid_no_rsp", 32'(rsp_valid), 0);
    end
    next_cycle();
    serve(1, 4'b1101, 1'b1, 2, 0);

    for (int i = 0; i < 24; i++) begin
      serve(int'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Controller that shares one external 4-bit registered barrel shifter (2-bit shift amount, direction select, 1-cycle latency) between two requesters.
- Extends the reach of that shifter: requesters may ask for logical shifts up to 2^AMT_W-1 positions. The block splits each request into multiple passes of at most 3 positions each.
- Sits between requester logic and the shifter instance. Returns one tagged result per accepted request on a valid/ready response port.

Parameters:
WIDTH, 4, data width; must match the shifter data width
AMT_W, 3, width of the requested shift amount (0..7)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted this cycle when high with req0_valid
req0_data  in  WIDTH  operand
req0_left  in  1  1 = shift left, 0 = shift right (logical, zero fill)
req0_amt  in  AMT_W  total shift amount
req1_valid, req1_ready, req1_data, req1_left, req1_amt  same as requester 0
sh_in  out  WIDTH  operand to shifter
sh_sa  out  2  shift amount to shifter
sh_left  out  1  direction to shifter
sh_out  in  WIDTH  shifter registered result, valid one cycle after inputs
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  1  requester index of result
rsp_data  out  WIDTH  final shifted value

Behaviour:
- One clock. Reset is synchronous and active-high.
- State machine has four states: IDLE, ISSUE, WAIT, DONE. Reset forces IDLE.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, req*_ready=0, sh_in=0, sh_sa=0, sh_left=0. Internal registers clear: work=0, rem=0, dir=0, id=0, rr_last=1, so requester 0 wins first.
- IDLE:
  - reqN_ready is combinational and asserted only in IDLE, only to the arbiter winner.
  - Arbitration is round-robin. If both are valid, grant the requester other than rr_last. If one is valid, grant it.
  - On accept: work<=data, rem<=amt, dir<=left, id<=N, rr_last<=N, go to ISSUE.
- ISSUE:
  - Drive sh_in=work, sh_left=dir, sh_sa=min(rem,3).
  - rem<=rem-min(rem,3). Go to WAIT.
- WAIT:
  - sh_in, sh_left and sh_sa hold their ISSUE values.
  - Capture work<=sh_out, which reflects the ISSUE-cycle inputs.
  - If rem==0, go to DONE; otherwise go to ISSUE.
- DONE:
  - rsp_valid=1, rsp_data=work, rsp_id=id.
  - Hold all three stable while rsp_ready=0. When rsp_ready=1, go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- sh_* outputs in IDLE and DONE: sh_sa=0; sh_in and sh_left hold their last values.
- amt=0: exactly one pass with sh_sa=0; the operand passes through unchanged.
- Pass count P = max(1, ceil(amt/3)). Example for amt=7: passes of 3, 3, 1.
- Latency: if accepted at cycle A, rsp_valid first rises at cycle A+1+2P. Examples: amt 1..3 gives A+3; amt 4..6 gives A+5; amt 7 gives A+7.
- Amount ≥ WIDTH yields all zeros. No special-casing: it falls out of the zero-fill passes.
- No input is sampled outside an IDLE accept. Requester fields may change freely while not accepted.
- Reset mid-operation: the in-flight request is abandoned with no response, and all outputs take their reset values the cycle after reset is sampled. The first request after reset follows the reset arbitration priority.
- A requester holding valid while the other is being served must not be dropped. It is granted on the next IDLE if it still wins arbitration.

Test Plan:
- reset, then req0 {data=1011, left=0, amt=2} -> req0_ready high one cycle; rsp_valid 3 cycles later with rsp_data=0010, rsp_id=0; sh_sa=2 seen in the ISSUE cycle.
- req1 {data=1011, left=1, amt=1} -> rsp_data=0110, rsp_id=1 at A+3. Then req1 {0001, left, amt=5} -> sh_sa sequence 3, 2; rsp_data=0000 at A+5.
- req0 {data=1011, left=0, amt=7} -> three passes (sh_sa 3, 3, 1); rsp_data=0000 at A+7. req0 {1011, right, amt=0} -> one pass with sh_sa=0; rsp_data=1011 at A+3.
- Both valid continuously after reset -> grants alternate 0, 1, 0, 1 and rsp_id follows the same order; no request is lost or duplicated.
- rsp_ready held low 4 cycles in DONE -> rsp_valid, rsp_data and rsp_id stable; both req*_ready stay 0; handshake on the 5th cycle returns the block to IDLE.
- Assert reset during WAIT of a 3-pass request -> no rsp_valid follows; the next cycle all outputs are 0; a subsequent req1 alone is served normally.
